// File: rtl/unified_mem_arbiter_if.sv
// Core/memory handshake bundle for unified_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the core + memory side.
interface unified_mem_arbiter_if;
  logic        i_req;
  logic [29:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        m_req;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, m_req, m_wen, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, m_req, m_wen, m_addr, m_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one 64-bit single-ported memory between the I-fetch and D ports, with an abort watchdog.
// Define ARB_RR_EN for round-robin tie breaking; otherwise D has fixed priority over I.
module unified_mem_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  unified_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int            CW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam bit            WDOG_EN  = (TIMEOUT_CYC != 0);

  state_t        state;
  logic          own_d;
  logic          i_half;
  logic [CW-1:0] cnt;
  logic          grant_d;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.d_addr[2:0];

`ifdef ARB_RR_EN
  // Last granted owner (1 = D); a tie goes to the side not served last.
  logic rr_last;

  always_comb begin
    grant_d = bus.d_req;
    if (bus.d_req && bus.i_req)
      grant_d = ~rr_last;
  end
`else
  always_comb begin
    grant_d = bus.d_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      own_d       <= 1'b0;
      i_half      <= 1'b0;
      cnt         <= '0;
      bus.m_req   <= 1'b0;
      bus.m_wen   <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_rdata <= '0;
      bus.i_ack   <= 1'b0;
      bus.i_err   <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
`ifdef ARB_RR_EN
      rr_last     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.d_req || bus.i_req) begin
            state     <= BUSY;
            bus.m_req <= 1'b1;
            own_d     <= grant_d;
`ifdef ARB_RR_EN
            rr_last   <= grant_d;
`endif
            if (grant_d) begin
              bus.m_addr  <= {bus.d_addr[31:3], 3'b000};
              bus.m_wen   <= bus.d_wen;
              bus.m_wdata <= bus.d_wdata;
            end else begin
              bus.m_addr <= {bus.i_addr[29:1], 3'b000};
              bus.m_wen  <= 1'b0;
              i_half     <= bus.i_addr[0];
            end
          end
        end

        BUSY: begin
          if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
          // Completion takes precedence over a watchdog abort in the same cycle.
          if (bus.m_ready) begin
            state     <= RESP;
            bus.m_req <= 1'b0;
            if (own_d) begin
              bus.d_ack <= 1'b1;
              if (!bus.m_wen)
                bus.d_rdata <= bus.m_rdata;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= i_half ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
            end
          end else if (WDOG_EN && (cnt == CNT_LAST)) begin
            state     <= RESP;
            bus.m_req <= 1'b0;
            if (own_d) begin
              bus.d_ack <= 1'b1;
              bus.d_err <= 1'b1;
            end else begin
              bus.i_ack <= 1'b1;
              bus.i_err <= 1'b1;
            end
          end
        end

        RESP: begin
          state     <= IDLE;
          cnt       <= '0;
          bus.i_ack <= 1'b0;
          bus.i_err <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.d_err <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (watchdog set to 4 cycles).
module tb_unified_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".m_req"},   64'(bus.m_req),   64'h0);
    chk({tag, ".m_wen"},   64'(bus.m_wen),   64'h0);
    chk({tag, ".m_addr"},  64'(bus.m_addr),  64'h0);
    chk({tag, ".m_wdata"}, bus.m_wdata,      64'h0);
    chk({tag, ".i_rdata"}, 64'(bus.i_rdata), 64'h0);
    chk({tag, ".d_rdata"}, bus.d_rdata,      64'h0);
    chk({tag, ".acks"},    64'({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}), 64'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wen   = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Fetch, odd word -> upper half, minimum 3-cycle transaction
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h5;
    bus.m_rdata = 64'hAAAA0000_BBBB1111;
    tick();
    chk("t1.m_req",  64'(bus.m_req),  64'h1);
    chk("t1.m_addr", 64'(bus.m_addr), 64'h10);
    chk("t1.m_wen",  64'(bus.m_wen),  64'h0);
    chk("t1.i_ack_early", 64'(bus.i_ack), 64'h0);
    bus.m_ready = 1'b1;
    tick();
    chk("t1.i_ack",   64'(bus.i_ack),   64'h1);
    chk("t1.i_err",   64'(bus.i_err),   64'h0);
    chk("t1.i_rdata", 64'(bus.i_rdata), 64'hAAAA0000);
    chk("t1.m_req_resp", 64'(bus.m_req), 64'h0);
    bus.i_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();
    chk("t1.i_ack_pulse", 64'(bus.i_ack),   64'h0);
    chk("t1.i_rdata_hold", 64'(bus.i_rdata), 64'hAAAA0000);

    // Data load
    bus.d_req   = 1'b1;
    bus.d_wen   = 1'b0;
    bus.d_addr  = 32'h208;
    bus.m_rdata = 64'hCAFEBABE_DEADBEEF;
    tick();
    chk("ld.m_addr", 64'(bus.m_addr), 64'h208);
    chk("ld.m_wen",  64'(bus.m_wen),  64'h0);
    bus.m_ready = 1'b1;
    tick();
    chk("ld.d_ack",   64'(bus.d_ack), 64'h1);
    chk("ld.d_rdata", bus.d_rdata,    64'hCAFEBABE_DEADBEEF);
    chk("ld.i_ack",   64'(bus.i_ack), 64'h0);
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();

    // Data store, unaligned address bits dropped, one wait cycle
    bus.d_req   = 1'b1;
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h107;
    bus.d_wdata = 64'h1234;
    bus.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("st.m_addr",  64'(bus.m_addr), 64'h100);
    chk("st.m_wen",   64'(bus.m_wen),  64'h1);
    chk("st.m_wdata", bus.m_wdata,     64'h1234);
    tick();
    chk("st.wait_m_req", 64'(bus.m_req), 64'h1);
    chk("st.wait_d_ack", 64'(bus.d_ack), 64'h0);
    bus.m_ready = 1'b1;
    tick();
    chk("st.d_ack",   64'(bus.d_ack), 64'h1);
    chk("st.d_err",   64'(bus.d_err), 64'h0);
    chk("st.d_rdata", bus.d_rdata,    64'hCAFEBABE_DEADBEEF);
    bus.d_req   = 1'b0;
    bus.d_wen   = 1'b0;
    bus.m_ready = 1'b0;
    tick();

    // Watchdog abort: memory never ready
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h500;
    bus.m_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("to.m_req_busy", 64'(bus.m_req), 64'h1);
      chk("to.d_ack_busy", 64'(bus.d_ack), 64'h0);
    end
    tick();
    chk("to.d_ack",   64'(bus.d_ack), 64'h1);
    chk("to.d_err",   64'(bus.d_err), 64'h1);
    chk("to.m_req",   64'(bus.m_req), 64'h0);
    chk("to.d_rdata", bus.d_rdata,    64'hCAFEBABE_DEADBEEF);
    bus.d_req = 1'b0;
    tick();
    chk("to.d_err_pulse", 64'(bus.d_err), 64'h0);

    // m_ready in the last watchdog cycle wins over the abort
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h508;
    bus.m_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    tick();
    tick();
    tick();
    bus.m_ready = 1'b1;
    tick();
    chk("race.d_ack",   64'(bus.d_ack), 64'h1);
    chk("race.d_err",   64'(bus.d_err), 64'h0);
    chk("race.d_rdata", bus.d_rdata,    64'h0123_4567_89AB_CDEF);
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();

    // Reset during BUSY, request held across it
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h6;
    bus.m_rdata = 64'h5555_6666_7777_8888;
    tick();
    chk("rst.m_req_before", 64'(bus.m_req), 64'h1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst.async");
    tick();
    chk("rst.i_ack_held", 64'(bus.i_ack), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("rst.m_req_restart", 64'(bus.m_req),  64'h1);
    chk("rst.m_addr",        64'(bus.m_addr), 64'h18);
    chk("rst.no_stale_ack",  64'(bus.i_ack),  64'h0);
    bus.m_ready = 1'b1;
    tick();
    chk("rst.i_ack",   64'(bus.i_ack),   64'h1);
    chk("rst.i_rdata", 64'(bus.i_rdata), 64'h77778888);
    bus.i_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();

    // Tie after reset: D first in both arbitration modes, then I once D drops
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h4;
    bus.d_req   = 1'b1;
    bus.d_wen   = 1'b0;
    bus.d_addr  = 32'h300;
    bus.m_rdata = 64'h1111_2222_3333_4444;
    tick();
    chk("tie.m_addr_d", 64'(bus.m_addr), 64'h300);
    bus.m_ready = 1'b1;
    tick();
    chk("tie.d_ack",   64'(bus.d_ack), 64'h1);
    chk("tie.i_ack_0", 64'(bus.i_ack), 64'h0);
    chk("tie.d_rdata", bus.d_rdata,    64'h1111_2222_3333_4444);
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();
    chk("tie.gap_acks", 64'({bus.i_ack, bus.d_ack}), 64'h0);
    chk("tie.gap_m_req", 64'(bus.m_req), 64'h0);
    tick();
    chk("tie.m_addr_i", 64'(bus.m_addr), 64'h10);
    bus.m_ready = 1'b1;
    tick();
    chk("tie.i_ack",   64'(bus.i_ack),   64'h1);
    chk("tie.d_ack_0", 64'(bus.d_ack),   64'h0);
    chk("tie.i_rdata", 64'(bus.i_rdata), 64'h33334444);
    bus.i_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();

    // Both requests held for four transactions; last grant was I
    bus.i_req   = 1'b1;
    bus.i_addr  = 30'h3;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h400;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
`ifdef ARB_RR_EN
      exp_d = ((k % 2) == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      chk("hold.m_addr", 64'(bus.m_addr), exp_d ? 64'h400 : 64'h8);
      tick();
      chk("hold.d_ack", 64'(bus.d_ack), 64'(exp_d));
      chk("hold.i_ack", 64'(bus.i_ack), 64'(!exp_d));
      tick();
    end
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
